// File: rtl/rr_arbiter16_pkg.sv
// Shared constants, FSM state type and rotate helper for the 16-way round-robin arbiter.
// Latency: n/a (declarations and a pure combinational function only).
// Backpressure: n/a.
// Contents: N_REQ, SEL_W, HOLD_MAX_DEF, CNT_W, state_e, rotr16().
package rr_arbiter16_pkg;

  localparam int N_REQ        = 16;  // requester count, fixed for this revision
  localparam int SEL_W        = 4;   // log2(N_REQ)
  localparam int HOLD_MAX_DEF = 8;   // default beats per grant (legal 1..255)
  localparam int CNT_W        = 8;   // wide enough to count up to 254 beats

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Rotate right so that bit 'amt' of vec lands at bit 0. The arbiter then
  // only has to find the lowest set bit to get the first requester at or
  // after the pointer.
  function automatic logic [N_REQ-1:0] rotr16(input logic [N_REQ-1:0] vec,
                                              input logic [SEL_W-1:0] amt);
    logic [2*N_REQ-1:0] dbl;
    dbl = {vec, vec} >> amt;
    return dbl[N_REQ-1:0];
  endfunction

endpackage

// File: rtl/rr_pick_next.sv
// Finds the first set request at or after ptr, wrapping modulo 16.
// Latency: purely combinational.
// Backpressure: none; recomputed every cycle from its inputs.
// Ports: req_i (request vector), ptr_i (search start), found_o (any request), idx_o (winner).
module rr_pick_next
  import rr_arbiter16_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  assign rot = rotr16(req_i, ptr_i);

  // Lowest-set-bit encoder: scanning downward leaves the lowest hit in off.
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = SEL_W'(i);
      end
    end
  end

  assign found_o = |req_i;
  // The 4-bit add wraps naturally, undoing the rotation modulo 16.
  assign idx_o   = ptr_i + off;

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter/sequencer: moves 1-bit beats from 16 requesters to one consumer.
// Latency: grant registered one edge after req is seen in IDLE; one IDLE bubble between grants.
// Backpressure: out_ready low holds the current beat and freezes the burst counter.
// Ports: clk, rst (sync, active-high); req[15:0], data_in[15:0], out_ready in;
//        out_valid, out_data, sel[3:0], grant[15:0] (one-hot, 0 when idle), busy out.
// Option: define RR_FIXED_PRIORITY_EN to make the IDLE search always start at lane 0.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF  // beats per grant before forced release, 1..255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_data,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] search_start;
  logic             beat_w;
  logic             last_beat_w;
  logic             release_w;

`ifdef RR_FIXED_PRIORITY_EN
  // Fixed priority: lowest index always wins; ptr keeps updating but is ignored.
  assign search_start = '0;
`else
  assign search_start = ptr_q;
`endif

  rr_pick_next u_pick (
    .req_i   (req),
    .ptr_i   (search_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Datapath: valid follows the owner's request so it can never be high
  // without an owner, and a dropped request cannot coincide with a beat.
  assign busy      = (state_q == ST_GRANT);
  assign out_valid = busy && req[sel_q];
  assign out_data  = out_valid && data_in[sel_q];
  assign sel       = sel_q;
  assign grant     = grant_q;

  assign beat_w      = out_valid && out_ready;
  assign last_beat_w = (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign release_w   = busy && (!req[sel_q] || (beat_w && last_beat_w));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d           = ST_GRANT;
          sel_d             = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          cnt_d             = '0;
        end
      end
      ST_GRANT: begin
        if (release_w) begin
          // sel keeps its value through IDLE; only grant reports ownership.
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = sel_q + 1'b1;
          cnt_d   = '0;
        end else if (beat_w) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: directed scenarios plus random traffic against a cycle model.
// Latency: n/a.
// Backpressure: out_ready is driven both directed and random.
module tb_rr_arbiter16;

  localparam int HM = 8;
`ifdef RR_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] data_in;
  logic        out_ready;
  logic        out_valid;
  logic        out_data;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        busy;

  always #5 clk = ~clk;

  rr_arbiter16 #(.HOLD_MAX(HM)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .grant     (grant),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the channel, where the next search starts,
  // and how many beats the owner has moved so far.
  bit m_busy  = 1'b0;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_beats = 0;

  int gseq[$];          // lanes observed at each new grant
  bit prev_busy  = 1'b0;
  int beats_seen = 0;

  function automatic int first_from(input logic [15:0] r, input int start);
    for (int k = 0; k < 16; k++) begin
      if (r[(start + k) % 16]) return (start + k) % 16;
    end
    return -1;
  endfunction

  function automatic int gq(input int i);
    return (i < gseq.size()) ? gseq[i] : -1;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_release();
    m_busy  = 1'b0;
    m_ptr   = (m_sel + 1) % 16;
    m_beats = 0;
  endtask

  // One clock: drive at the falling edge, check after settling, then advance
  // the model to what the next rising edge should produce.
  task automatic step(input logic r, input logic [15:0] q, input logic [15:0] d, input logic rdy);
    logic [15:0] e_grant;
    logic        e_valid;
    logic        e_data;
    @(negedge clk);
    rst       = r;
    req       = q;
    data_in   = d;
    out_ready = rdy;
    #1;
    e_valid = m_busy && q[m_sel];
    e_data  = e_valid && d[m_sel];
    e_grant = m_busy ? (16'h0001 << m_sel) : 16'h0000;
    chk("grant", grant, e_grant);
    chk("sel", {12'h000, sel}, 16'(m_sel));
    chk("busy", {15'h0000, busy}, {15'h0000, m_busy});
    chk("out_valid", {15'h0000, out_valid}, {15'h0000, e_valid});
    chk("out_data", {15'h0000, out_data}, {15'h0000, e_data});
    if (busy && !prev_busy) gseq.push_back(int'(sel));
    prev_busy = busy;
    if (out_valid && out_ready) beats_seen++;

    if (r) begin
      m_busy = 1'b0; m_sel = 0; m_ptr = 0; m_beats = 0;
    end else if (!m_busy) begin
      if (q != 16'h0000) begin
        m_sel   = first_from(q, FIXED ? 0 : m_ptr);
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else if (!q[m_sel]) begin
      model_release();
    end else if (e_valid && rdy) begin
      m_beats++;
      if (m_beats == HM) model_release();
    end
  endtask

  logic [15:0] rq;

  initial begin
    // 1. Reset held with every lane requesting: nothing may be granted.
    rst = 1'b1; req = 16'hFFFF; data_in = 16'h0000; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);

    // 2. Lone requester 5: two bursts separated by one bubble.
    gseq.delete();
    repeat (22) step(1'b0, 16'h0020, 16'h0020, 1'b1);
    chk_int("lane5_first", gq(0), 5);
    chk_int("lane5_regrant", gq(1), 5);

    // 3. All lanes requesting after a mid-burst reset: strict rotation from 0.
    step(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    gseq.delete();
    repeat (17 * (HM + 1) + 2) step(1'b0, 16'hFFFF, 16'($urandom), 1'b1);
    for (int k = 0; k < 17; k++) chk_int("rotation", gq(k), FIXED ? 0 : k % 16);

    // 4. Backpressure on lane 3: five stalled cycles then a full burst.
    step(1'b1, 16'h0000, 16'h0000, 1'b1);
    beats_seen = 0;
    step(1'b0, 16'h0008, 16'hFFFF, 1'b0);
    repeat (5) step(1'b0, 16'h0008, 16'hFFFF, 1'b0);
    chk_int("stall_beats", beats_seen, 0);
    repeat (HM) step(1'b0, 16'h0008, 16'hFFFF, 1'b1);
    chk_int("burst_beats", beats_seen, HM);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);

    // 5. Pointer parked at 15, lane 15 drops after 3 beats, next is lane 2.
    step(1'b1, 16'h0000, 16'h0000, 1'b1);
    step(1'b0, 16'h4000, 16'h4000, 1'b1);
    step(1'b0, 16'h4000, 16'h4000, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    gseq.delete();
    step(1'b0, 16'h8004, 16'h8004, 1'b1);
    repeat (3) step(1'b0, 16'h8004, 16'h8004, 1'b1);
    repeat (4) step(1'b0, 16'h0004, 16'h0004, 1'b1);
    chk_int("wrap_first", gq(0), FIXED ? 2 : 15);
    if (!FIXED) chk_int("wrap_second", gq(1), 2);

`ifdef RR_FIXED_PRIORITY_EN
    // 6. Lane 0 keeps winning over lane 3 until it stops requesting.
    step(1'b1, 16'h0000, 16'h0000, 1'b1);
    gseq.delete();
    repeat (40) step(1'b0, 16'h0009, 16'h0009, 1'b1);
    for (int k = 0; k < gseq.size(); k++) chk_int("fixed_lane0", gseq[k], 0);
    gseq.delete();
    repeat (4) step(1'b0, 16'h0008, 16'h0008, 1'b1);
    chk_int("fixed_lane3", gq(0), 3);
`endif

    // 7. Random traffic: sticky requests, random data/ready, rare resets.
    rq = 16'h0000;
    repeat (800) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(7) == 0) rq[i] = ~rq[i];
      end
      step(($urandom_range(199) == 0), rq, 16'($urandom), ($urandom_range(3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
